y_stream_monitor: RTL and testbench

Serial-stream consumer that sits directly downstream of the Activity 3 dataflow sequence circuit and samples its 1-bit output `y` on every enabled clock. It detects a parameterized bit pattern with overlap, counts matches into a saturating counter, and tracks the current and longest run of consecutive ones. Its outputs give the bench and downstream logic a cycle-accurate, self-checking view of the generated sequence.

---
 rtl/y_stream_monitor.sv | 107 ++++++++++
 tb/tb_y_stream_monitor.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/y_stream_monitor.sv
// Serial monitor for the upstream sequence output: overlapping pattern match,
// saturating match counter, and current/longest run-of-ones tracking.
//   state | meaning
//   FILL  | fewer than PAT_LEN samples taken since reset/clear
//   TRACK | history holds a full window; matches may fire
module y_stream_monitor #(
  parameter int unsigned PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
  parameter int unsigned CNT_W = 8,
  parameter int unsigned RUN_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             y_in,
  input  logic             en,
  input  logic             clear,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic             count_sat,
  output logic [RUN_W-1:0] ones_run,
  output logic [RUN_W-1:0] max_run
);

  typedef enum logic {FILL = 1'b0, TRACK = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [2:0]         fill_q, fill_d;
  logic [PAT_LEN-1:0] hist_q, hist_d;
  logic               match_q, match_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               sat_q, sat_d;
  logic [RUN_W-1:0]   run_q, run_d;
  logic [RUN_W-1:0]   max_q, max_d;
  logic               full;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FILL;
      fill_q  <= '0;
      hist_q  <= '0;
      match_q <= 1'b0;
      count_q <= '0;
      sat_q   <= 1'b0;
      run_q   <= '0;
      max_q   <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      hist_q  <= hist_d;
      match_q <= match_d;
      count_q <= count_d;
      sat_q   <= sat_d;
      run_q   <= run_d;
      max_q   <= max_d;
    end
  end

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    hist_d  = hist_q;
    match_d = 1'b0;
    count_d = count_q;
    sat_d   = sat_q;
    run_d   = run_q;
    max_d   = max_q;
    full    = 1'b0;
    if (clear) begin
      // a sample arriving together with clear is dropped
      state_d = FILL;
      fill_d  = '0;
      hist_d  = '0;
      count_d = '0;
      sat_d   = 1'b0;
      run_d   = '0;
      max_d   = '0;
    end else if (en) begin
      hist_d = {hist_q[PAT_LEN-2:0], y_in};
      full   = (state_q == TRACK) || (fill_q == 3'(PAT_LEN - 1));
      if (full) begin
        state_d = TRACK;
      end else begin
        fill_d = fill_q + 3'd1;
      end
      match_d = full && (hist_d == PATTERN);
      if (match_d && (count_q != '1)) begin
        count_d = count_q + CNT_W'(1);
      end
      sat_d = sat_q || (count_d == '1);
      if (y_in) begin
        if (run_q != '1) begin
          run_d = run_q + RUN_W'(1);
        end
      end else begin
        run_d = '0;
      end
      max_d = (run_d > max_q) ? run_d : max_q;
    end
  end

  assign match       = match_q;
  assign match_count = count_q;
  assign count_sat   = sat_q;
  assign ones_run    = run_q;
  assign max_run     = max_q;

endmodule

// File: tb/tb_y_stream_monitor.sv
// Directed bench for y_stream_monitor: default instance plus a narrow-counter
// instance (CNT_W=2, RUN_W=3) sharing the same stimulus.
module tb_y_stream_monitor;

  logic clk = 1'b0;
  logic reset, y_in, en, clear;
  logic       match_a, sat_a;
  logic [7:0] count_a;
  logic [5:0] run_a, max_a;
  logic       match_b, sat_b;
  logic [1:0] count_b;
  logic [2:0] run_b, max_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  y_stream_monitor u_a (
    .clk(clk), .reset(reset), .y_in(y_in), .en(en), .clear(clear),
    .match(match_a), .match_count(count_a), .count_sat(sat_a),
    .ones_run(run_a), .max_run(max_a)
  );

  y_stream_monitor #(.CNT_W(2), .RUN_W(3)) u_b (
    .clk(clk), .reset(reset), .y_in(y_in), .en(en), .clear(clear),
    .match(match_b), .match_count(count_b), .count_sat(sat_b),
    .ones_run(run_b), .max_run(max_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic c, input logic e, input logic y);
    reset = r; clear = c; en = e; y_in = y;
    @(posedge clk);
    #1;
  endtask

  task automatic samp(input logic y);
    step(1'b0, 1'b0, 1'b1, y);
  endtask

  task automatic do_clear();
    step(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    logic [6:0] ovl;
    logic [6:0] ovl_m;
    logic [9:0] runs;
    ovl   = 7'b1011011;
    ovl_m = 7'b0001001;
    runs  = 10'b1110111110;

    // reset state
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    chk("rst_match", {31'd0, match_a}, 0);
    chk("rst_count", {24'd0, count_a}, 0);
    chk("rst_sat", {31'd0, sat_a}, 0);
    chk("rst_run", {26'd0, run_a}, 0);
    chk("rst_max", {26'd0, max_a}, 0);

    // overlap: 1,0,1,1,0,1,1 -> match after samples 4 and 7
    for (int i = 6; i >= 0; i--) begin
      samp(ovl[i]);
      chk($sformatf("ovl_match_%0d", 7 - i), {31'd0, match_a}, {31'd0, ovl_m[i]});
    end
    chk("ovl_count", {24'd0, count_a}, 2);
    chk("ovl_sat", {31'd0, sat_a}, 0);
    chk("ovl_run", {26'd0, run_a}, 2);
    chk("ovl_max", {26'd0, max_a}, 2);

    // run tracking: 1,1,1,0,1,1,1,1,1,0
    do_clear();
    chk("clr_count", {24'd0, count_a}, 0);
    for (int i = 9; i >= 0; i--) begin
      samp(runs[i]);
      if (i == 7) chk("run_after3", {26'd0, run_a}, 3);
    end
    chk("run_final", {26'd0, run_a}, 0);
    chk("run_max", {26'd0, max_a}, 5);
    chk("run_count", {24'd0, count_a}, 1);

    // enable gating: 1,0,1, two idle cycles with y=0, then 1
    do_clear();
    samp(1'b1); samp(1'b0); samp(1'b1);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      chk("gap_match", {31'd0, match_a}, 0);
      chk("gap_run", {26'd0, run_a}, 1);
      chk("gap_max", {26'd0, max_a}, 1);
      chk("gap_count", {24'd0, count_a}, 0);
    end
    samp(1'b1);
    chk("gate_match", {31'd0, match_a}, 1);
    chk("gate_count", {24'd0, count_a}, 1);
    samp(1'b0);
    chk("gate_match_drop", {31'd0, match_a}, 0);

    // counter saturation on the narrow instance
    do_clear();
    for (int k = 1; k <= 5; k++) begin
      samp(1'b1); samp(1'b0); samp(1'b1); samp(1'b1);
      chk($sformatf("sat_match_%0d", k), {31'd0, match_b}, 1);
      chk($sformatf("sat_count_%0d", k), {30'd0, count_b}, (k >= 3) ? 3 : k);
      chk($sformatf("sat_flag_%0d", k), {31'd0, sat_b}, (k >= 3) ? 1 : 0);
    end
    chk("wide_count", {24'd0, count_a}, 5);
    chk("wide_sat", {31'd0, sat_a}, 0);

    // run saturation: 10 ones
    do_clear();
    for (int i = 0; i < 10; i++) samp(1'b1);
    chk("runsat_run", {29'd0, run_b}, 7);
    chk("runsat_max", {29'd0, max_b}, 7);
    chk("wide_run", {26'd0, run_a}, 10);
    chk("wide_max", {26'd0, max_a}, 10);

    // reset mid-stream
    do_clear();
    samp(1'b1); samp(1'b0); samp(1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    chk("mid_rst_run", {26'd0, run_a}, 0);
    chk("mid_rst_max", {26'd0, max_a}, 0);
    chk("mid_rst_count", {24'd0, count_a}, 0);
    samp(1'b1);
    chk("mid_no_match", {31'd0, match_a}, 0);
    chk("mid_run1", {26'd0, run_a}, 1);
    samp(1'b1); samp(1'b0); samp(1'b1);
    chk("mid_fill_no_match", {31'd0, match_a}, 0);
    samp(1'b1);
    chk("mid_match", {31'd0, match_a}, 1);
    chk("mid_count", {24'd0, count_a}, 1);

    // clear colliding with an enabled sample
    do_clear();
    for (int i = 6; i >= 0; i--) samp(ovl[i]);
    chk("col_pre_count", {24'd0, count_a}, 2);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    chk("col_match", {31'd0, match_a}, 0);
    chk("col_count", {24'd0, count_a}, 0);
    chk("col_run", {26'd0, run_a}, 0);
    chk("col_max", {26'd0, max_a}, 0);
    chk("col_sat", {31'd0, sat_a}, 0);
    samp(1'b1); samp(1'b0); samp(1'b1); samp(1'b1);
    chk("col_post_match", {31'd0, match_a}, 1);
    chk("col_post_count", {24'd0, count_a}, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
